// File: rtl/sum_div_pkg.sv
// Shared definitions for the adder datapath and the sum divider.
package sum_div_pkg;

    localparam int unsigned SUM_W  = 10;
    localparam int unsigned OPND_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/sum_divider_if.sv
// Input and output valid/ready handshakes of the sum divider.
interface sum_divider_if
    import sum_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = SUM_W,
    parameter int unsigned DIVISOR_W  = OPND_W
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] in_dividend;
    logic [DIVISOR_W-1:0]  in_divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] out_quotient;
    logic [DIVISOR_W-1:0]  out_remainder;
    logic                  out_div_by_zero;

    // Producer/consumer side.
    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );

    // Divider side.
    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );

endinterface

// File: rtl/sum_div_step.sv
// One restoring-division step: shift the next dividend bit in, compare, subtract.
module sum_div_step #(
    parameter int unsigned DIVIDEND_W = 10,
    parameter int unsigned DIVISOR_W  = 8
) (
    input  logic [DIVISOR_W-1:0]  rem,
    input  logic [DIVIDEND_W-1:0] quo,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVISOR_W-1:0]  rem_next,
    output logic [DIVIDEND_W-1:0] quo_next
);

    logic [DIVISOR_W:0] trial;
    logic               fits;

    always_comb begin
        // One extra bit so the shifted partial remainder cannot overflow.
        trial = {rem, quo[DIVIDEND_W-1]};
        fits  = trial >= {1'b0, divisor};
        if (fits) begin
            rem_next = DIVISOR_W'(trial - {1'b0, divisor});
        end else begin
            rem_next = trial[DIVISOR_W-1:0];
        end
        quo_next = (quo << 1) | DIVIDEND_W'(fits);
    end

endmodule

// File: rtl/sum_divider.sv
// Sequential restoring divider for the adder-tree sum, one quotient bit per cycle.
module sum_divider
    import sum_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = SUM_W,
    parameter int unsigned DIVISOR_W  = OPND_W
) (
    input logic         clk,
    input logic         rst_n,
    sum_divider_if.slave bus
);

    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    state_e                state_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  div_by_zero_q;

    logic [DIVISOR_W-1:0]  rem_next;
    logic [DIVIDEND_W-1:0] quo_next;

    sum_div_step #(
        .DIVIDEND_W(DIVIDEND_W),
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            quo_q         <= '0;
            rem_q         <= '0;
            divisor_q     <= '0;
            cnt_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        divisor_q  <= bus.in_divisor;
                        cnt_q      <= CNT_W'(DIVIDEND_W - 1);
                        in_ready_q <= 1'b0;
                        if (bus.in_divisor == '0) begin
                            // Result is fully known at accept; skip the iteration.
                            quo_q         <= '1;
                            rem_q         <= bus.in_dividend[DIVISOR_W-1:0];
                            div_by_zero_q <= 1'b1;
                            out_valid_q   <= 1'b1;
                            state_q       <= StDone;
                        end else begin
                            quo_q         <= bus.in_dividend;
                            rem_q         <= '0;
                            div_by_zero_q <= 1'b0;
                            state_q       <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    quo_q <= quo_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_quotient    = quo_q;
    assign bus.out_remainder   = rem_q;
    assign bus.out_div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_sum_divider.sv
// Self-checking bench for sum_divider against an arithmetic reference model.
module tb_sum_divider;

    localparam int DW = 10;
    localparam int VW = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sum_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

    sum_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned division; divide-by-zero yields all ones and the low dividend bits.
    task automatic ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           output logic [DW-1:0] q, output logic [VW-1:0] r,
                           output logic z, output int lat);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q   = '1;
            r   = a[VW-1:0];
            z   = 1'b1;
            lat = 1;
        end else begin
            q   = DW'(ai / bi);
            r   = VW'(ai % bi);
            z   = 1'b0;
            lat = DW + 1;
        end
    endtask

    // Drives one operation; lat counts cycles from the accept cycle (cycle 0) to out_valid.
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int stall,
                          output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z,
                          output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        q   = '0;
        r   = '0;
        z   = 1'b0;
        lat = 0;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0;
            return;
        end
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.out_ready   = (stall == 0);
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_dividend = DW'($urandom);
        bus.in_divisor  = VW'($urandom);
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        if (!bus.out_valid) begin
            ok            = 1'b0;
            bus.out_ready = 1'b1;
            return;
        end
        q = bus.out_quotient;
        r = bus.out_remainder;
        z = bus.out_div_by_zero;
        repeat (stall) @(negedge clk);
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        total += 5;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid);
        end
        if (bus.out_quotient !== '0) begin
            bad++; $display("FAIL reset_quotient got=%0d want=0", bus.out_quotient);
        end
        if (bus.out_remainder !== '0) begin
            bad++; $display("FAIL reset_remainder got=%0d want=0", bus.out_remainder);
        end
        if (bus.out_div_by_zero !== 1'b0) begin
            bad++; $display("FAIL reset_dbz got=%0b want=0", bus.out_div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [DW-1:0] a_tab [4];
        logic [VW-1:0] b_tab [4];
        logic [DW-1:0] q, eq;
        logic [VW-1:0] r, er;
        logic          z, ez;
        int            lat, elat;
        bit            ok;
        a_tab = '{10'd1020, 10'd1000, 10'd5, 10'h2AB};
        b_tab = '{8'd255, 8'd7, 8'd9, 8'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(a_tab[i], b_tab[i], 0, q, r, z, lat, ok);
            ref_div(a_tab[i], b_tab[i], eq, er, ez, elat);
            total += 4;
            if (!ok || q !== eq) begin
                bad++; $display("FAIL directed_q %0d/%0d got=%0d want=%0d", a_tab[i], b_tab[i], q, eq);
            end
            if (!ok || r !== er) begin
                bad++; $display("FAIL directed_r %0d/%0d got=%0d want=%0d", a_tab[i], b_tab[i], r, er);
            end
            if (!ok || z !== ez) begin
                bad++; $display("FAIL directed_dbz %0d/%0d got=%0b want=%0b", a_tab[i], b_tab[i], z, ez);
            end
            if (!ok || lat != elat) begin
                bad++; $display("FAIL directed_latency %0d/%0d got=%0d want=%0d", a_tab[i], b_tab[i], lat, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_dividend = 10'd1000;
        bus.in_divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.in_dividend = 10'd100;
        bus.in_divisor  = 8'd3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 40);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total += 4;
            if (bus.out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_out_valid cyc=%0d got=%0b want=1", i, bus.out_valid);
            end
            if (bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b want=0", i, bus.in_ready);
            end
            if (bus.out_quotient !== 10'd142) begin
                bad++; $display("FAIL bp_quotient cyc=%0d got=%0d want=142", i, bus.out_quotient);
            end
            if (bus.out_remainder !== 8'd6) begin
                bad++; $display("FAIL bp_remainder cyc=%0d got=%0d want=6", i, bus.out_remainder);
            end
        end
        // in_valid stays high across the handoff edge; it must not be taken there.
        bus.out_ready = 1'b1;
        @(negedge clk);
        total += 3;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release_valid got=%0b want=0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready got=%0b want=1", bus.in_ready);
        end
        if (bus.out_quotient !== 10'd142) begin
            bad++; $display("FAIL bp_no_accept quotient got=%0d want=142", bus.out_quotient);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        int            lat;
        bit            ok;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 10'd500;
        bus.in_divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total += 5;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_in_ready got=%0b want=1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_out_valid got=%0b want=0", bus.out_valid);
        end
        if (bus.out_quotient !== '0) begin
            bad++; $display("FAIL midrst_quotient got=%0d want=0", bus.out_quotient);
        end
        if (bus.out_remainder !== '0) begin
            bad++; $display("FAIL midrst_remainder got=%0d want=0", bus.out_remainder);
        end
        if (bus.out_div_by_zero !== 1'b0) begin
            bad++; $display("FAIL midrst_dbz got=%0b want=0", bus.out_div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(10'd1023, 8'd1, 0, q, r, z, lat, ok);
        total += 1;
        if (!ok || q !== 10'd1023 || r !== 8'd0 || z !== 1'b0) begin
            bad++; $display("FAIL midrst_next_op got q=%0d r=%0d z=%0b want q=1023 r=0 z=0", q, r, z);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, q, eq;
        logic [VW-1:0] b, r, er;
        logic          z, ez;
        int            lat, elat, stall;
        bit            ok;
        for (int i = 0; i < 200; i++) begin
            a     = DW'($urandom_range(1023, 0));
            b     = ($urandom_range(9, 0) == 0) ? '0 : VW'($urandom_range(255, 1));
            stall = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
            run_op(a, b, stall, q, r, z, lat, ok);
            ref_div(a, b, eq, er, ez, elat);
            total += 1;
            if (!ok || q !== eq || r !== er || z !== ez || lat != elat) begin
                bad++;
                $display("FAIL random %0d/%0d got q=%0d r=%0d z=%0b lat=%0d want q=%0d r=%0d z=%0b lat=%0d",
                         a, b, q, r, z, lat, eq, er, ez, elat);
            end
        end
    endtask

    task automatic test_sweep();
        logic [VW-1:0] div_tab [5];
        logic [DW-1:0] a, q, eq;
        logic [VW-1:0] r, er;
        logic          z, ez;
        int            lat, elat;
        bit            ok;
        div_tab = '{8'd1, 8'd3, 8'd4, 8'd128, 8'd255};
        for (int d = 0; d < 5; d++) begin
            for (int ai = 0; ai < 1024; ai++) begin
                a = DW'(ai);
                run_op(a, div_tab[d], 0, q, r, z, lat, ok);
                ref_div(a, div_tab[d], eq, er, ez, elat);
                total += 1;
                if (!ok || q !== eq || r !== er || z !== ez || lat != elat) begin
                    bad++;
                    $display("FAIL sweep %0d/%0d got q=%0d r=%0d z=%0b lat=%0d want q=%0d r=%0d lat=%0d",
                             a, div_tab[d], q, r, z, lat, eq, er, elat);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_sweep();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
